// File: rtl/serv_ibus_fetch.sv
`default_nettype none
// ============================================================================
// Module   : serv_ibus_fetch
// Purpose  : Instruction-fetch bridge between the SERV core ibus and a
//            Wishbone instruction memory. Registers the Wishbone request,
//            captures the returned word, hands it to the core with a single
//            cycle acknowledge, and aborts a fetch that waits TIMEOUT cycles
//            (returning ERR_INSN with an o_err pulse). TIMEOUT=0 disables
//            the abort.
// Options  : SERV_IBUS_PREFETCH_EN - one-entry sequential prefetch buffer,
//            refilled with the word at A+4 after every good fetch of A.
// Revision : 1.0 - initial release
// ============================================================================
module serv_ibus_fetch #(
    parameter int          AW       = 32,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_INSN = 32'h00000000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    output logic [AW-1:0] o_wb_adr,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_err
);

    localparam int            CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] C_CNT_MAX  = {CW{1'b1}};
    localparam logic [AW-1:0] C_ADR_STEP = AW'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
`ifdef SERV_IBUS_PREFETCH_EN
        S_RESP = 2'd2,
        S_PF   = 2'd3
`else
        S_RESP = 2'd2
`endif
    } state_t;

    state_t        r_state,  w_state_nxt;
    logic [AW-1:0] r_wb_adr, w_wb_adr_nxt;
    logic          r_wb_cyc, w_wb_cyc_nxt;
    logic          r_ack,    w_ack_nxt;
    logic [31:0]   r_rdt,    w_rdt_nxt;
    logic          r_err,    w_err_nxt;
    logic [CW-1:0] r_cnt,    w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_expired;
    logic          w_buf_hit;
    logic [31:0]   w_buf_dat;
    logic [AW-1:0] w_adr_aligned;
    logic [1:0]    w_unused_adr_lsb;

`ifdef SERV_IBUS_PREFETCH_EN
    // The buffer tag is r_wb_adr itself: nothing rewrites r_wb_adr while the
    // buffer is valid, because every new REQ or PF first invalidates it.
    logic          r_buf_vld, w_buf_vld_nxt;
    logic [31:0]   r_buf_dat, w_buf_dat_nxt;
    logic          w_tag_hit;

    assign w_tag_hit = (i_ibus_adr[AW-1:2] == r_wb_adr[AW-1:2]);
    assign w_buf_hit = r_buf_vld && w_tag_hit;
    assign w_buf_dat = r_buf_dat;
`else
    assign w_buf_hit = 1'b0;
    assign w_buf_dat = 32'h0;
`endif

    // The core byte-offset bits never reach the bus.
    assign w_unused_adr_lsb = i_ibus_adr[1:0];
    assign w_adr_aligned    = {i_ibus_adr[AW-1:2], 2'b00};

    // Saturating wait-cycle counter and expiry on its last allowed value.
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    assign w_expired = (TIMEOUT != 0) && (r_cnt == C_CNT_LAST);

    // Next-state and next-output decode; all outputs are registered.
    always_comb begin
        w_state_nxt  = r_state;
        w_wb_adr_nxt = r_wb_adr;
        w_wb_cyc_nxt = r_wb_cyc;
        w_ack_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        w_rdt_nxt    = r_rdt;
        w_cnt_nxt    = r_cnt;
`ifdef SERV_IBUS_PREFETCH_EN
        w_buf_vld_nxt = r_buf_vld;
        w_buf_dat_nxt = r_buf_dat;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_ibus_cyc) begin
                    if (w_buf_hit) begin
                        w_ack_nxt   = 1'b1;
                        w_rdt_nxt   = w_buf_dat;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_wb_adr_nxt = w_adr_aligned;
                        w_wb_cyc_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_REQ;
                    end
`ifdef SERV_IBUS_PREFETCH_EN
                    w_buf_vld_nxt = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (i_wb_ack) begin
                    w_rdt_nxt    = i_wb_rdt;
                    w_wb_cyc_nxt = 1'b0;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = S_RESP;
                end else if (w_expired) begin
                    w_rdt_nxt    = ERR_INSN;
                    w_wb_cyc_nxt = 1'b0;
                    w_ack_nxt    = 1'b1;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = S_RESP;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RESP: begin
                // i_ibus_cyc is still the old request here and is ignored.
`ifdef SERV_IBUS_PREFETCH_EN
                if (!r_err) begin
                    w_wb_adr_nxt = r_wb_adr + C_ADR_STEP;
                    w_wb_cyc_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_PF;
                end else begin
                    w_state_nxt = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
`ifdef SERV_IBUS_PREFETCH_EN
            S_PF: begin
                if (i_wb_ack) begin
                    w_wb_cyc_nxt = 1'b0;
                    if (i_ibus_cyc && w_tag_hit) begin
                        // Core is already waiting for this word: forward it.
                        w_ack_nxt   = 1'b1;
                        w_rdt_nxt   = i_wb_rdt;
                        w_state_nxt = S_RESP;
                    end else if (i_ibus_cyc) begin
                        // Taken branch: drop the sequential word, refetch.
                        w_buf_vld_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_buf_vld_nxt = 1'b1;
                        w_buf_dat_nxt = i_wb_rdt;
                        w_state_nxt   = S_IDLE;
                    end
                end else if (w_expired) begin
                    w_wb_cyc_nxt  = 1'b0;
                    w_buf_vld_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
`endif
            default: begin
                w_wb_cyc_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_wb_adr <= '0;
            r_wb_cyc <= 1'b0;
            r_ack    <= 1'b0;
            r_rdt    <= 32'h0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
`ifdef SERV_IBUS_PREFETCH_EN
            r_buf_vld <= 1'b0;
            r_buf_dat <= 32'h0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_wb_adr <= w_wb_adr_nxt;
            r_wb_cyc <= w_wb_cyc_nxt;
            r_ack    <= w_ack_nxt;
            r_rdt    <= w_rdt_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
`ifdef SERV_IBUS_PREFETCH_EN
            r_buf_vld <= w_buf_vld_nxt;
            r_buf_dat <= w_buf_dat_nxt;
`endif
        end
    end

    assign o_ibus_rdt = r_rdt;
    assign o_ibus_ack = r_ack;
    assign o_wb_adr   = r_wb_adr;
    assign o_wb_cyc   = r_wb_cyc;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serv_ibus_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_serv_ibus_fetch
// Purpose  : Self-checking bench for serv_ibus_fetch. A Wishbone slave model
//            answers from a hashed memory after a programmable wait; each
//            core fetch is checked against a transaction-level prediction of
//            latency, data, error flag and bus activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serv_ibus_fetch;

    localparam int          AW       = 32;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] ERR_INSN = 32'h00000000;
    localparam int          HANG     = 1000;
    localparam int          GAP      = TIMEOUT + 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ibus_adr;
    logic          ibus_cyc;
    logic [31:0]   ibus_rdt;
    logic          ibus_ack;
    logic [AW-1:0] wb_adr;
    logic          wb_cyc;
    logic [31:0]   wb_rdt;
    logic          wb_ack;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model state
    int          sl_wait     = 0;
    bit          sl_hang     = 0;
    bit          sl_force    = 0;
    int          sl_cnt      = 0;
    int          sl_n_cyc    = 0;
    int          sl_last_len = 0;
    bit          sl_prev_ack = 0;
    logic [31:0] sl_last_adr = 32'h0;
    logic [31:0] sl_adr_log[$];

`ifdef SERV_IBUS_PREFETCH_EN
    // Predicted prefetch buffer contents
    bit          m_pf_vld = 0;
    logic [31:0] m_pf_tag = 32'h0;
`endif

    serv_ibus_fetch #(
        .AW       (AW),
        .TIMEOUT  (TIMEOUT),
        .ERR_INSN (ERR_INSN)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .o_wb_adr   (wb_adr),
        .o_wb_cyc   (wb_cyc),
        .i_wb_rdt   (wb_rdt),
        .i_wb_ack   (wb_ack),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00000013;
        if (a == 32'h300) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Wishbone slave: acks sl_wait cycles after cyc rises (0 = same cycle).
    initial begin
        wb_ack = 1'b0;
        wb_rdt = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (sl_prev_ack) check_eq("wb_cyc_drop_after_ack", 32'(wb_cyc), 32'd0);
            if (sl_force) begin
                wb_ack = 1'b1;
                wb_rdt = 32'hBAD00BAD;
            end else if (wb_cyc) begin
                if (sl_cnt == 0) begin
                    sl_n_cyc++;
                    sl_last_adr = wb_adr;
                    sl_adr_log.push_back(wb_adr);
                end
                wb_ack = !sl_hang && (sl_cnt == sl_wait);
                wb_rdt = wb_ack ? mem_word(wb_adr) : $urandom;
                sl_cnt++;
                sl_last_len = sl_cnt;
            end else begin
                wb_ack = 1'b0;
                sl_cnt = 0;
            end
            sl_prev_ack = wb_ack;
        end
    end

    task automatic idle(input int n);
        ibus_cyc = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One core fetch; wait_cyc is the slave wait (>= HANG: slave never acks).
    task automatic fetch(input logic [31:0] adr, input int wait_cyc);
        logic [31:0] a;
        logic [31:0] exp_dat;
        bit          hit;
        bit          exp_err;
        bit          seen;
        int          eff;
        int          exp_lat;
        int          lat;
        int          n_cyc0;
        a   = {adr[31:2], 2'b00};
        hit = 1'b0;
`ifdef SERV_IBUS_PREFETCH_EN
        hit = m_pf_vld && (m_pf_tag == a);
`endif
        eff     = (wait_cyc < TIMEOUT - 1) ? wait_cyc : TIMEOUT - 1;
        exp_err = !hit && (wait_cyc > TIMEOUT - 1);
        exp_lat = hit ? 1 : 2 + eff;
        exp_dat = exp_err ? ERR_INSN : mem_word(a);
        sl_wait = wait_cyc;
        sl_hang = (wait_cyc >= HANG);
        n_cyc0  = sl_n_cyc;
        ibus_adr = adr;
        ibus_cyc = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (ibus_ack) seen = 1'b1;
        end
        check_eq("ack_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_eq("ack_latency", 32'(lat), 32'(exp_lat));
            check_eq("ibus_rdt", ibus_rdt, exp_dat);
            check_eq("err_flag", 32'(err), 32'(exp_err));
            if (hit) begin
                check_eq("hit_no_wb_cycle", 32'(sl_n_cyc - n_cyc0), 32'd0);
            end else begin
                check_eq("wb_cycles", 32'(sl_n_cyc - n_cyc0), 32'd1);
                check_eq("wb_adr", sl_last_adr, a);
                check_eq("wb_cyc_len", 32'(sl_last_len), 32'(eff + 1));
            end
        end
        ibus_cyc = 1'b0;
        ibus_adr = $urandom;
        @(negedge clk);
        check_eq("ack_single_cycle", 32'(ibus_ack), 32'd0);
        check_eq("err_single_cycle", 32'(err), 32'd0);
`ifdef SERV_IBUS_PREFETCH_EN
        if (exp_err) begin
            m_pf_vld = 1'b0;
        end else begin
            m_pf_tag = a + 32'd4;
            m_pf_vld = (wait_cyc <= TIMEOUT - 1);
        end
`endif
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] last_a;
        int          rw;
`ifdef SERV_IBUS_PREFETCH_EN
        int          n0;
        int          lat;
        bit          seen;
`endif
        rst      = 1'b1;
        ibus_cyc = 1'b0;
        ibus_adr = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_ibus_ack", 32'(ibus_ack), 32'd0);
        check_eq("rst_ibus_rdt", ibus_rdt, 32'h0);
        check_eq("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        check_eq("rst_wb_adr", wb_adr, 32'h0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        idle(2);

        // Directed cases: zero wait, wait states with unaligned address,
        // hung slave, recovery, ack on the last allowed cycle, one past it.
        fetch(32'h100, 0);    idle(GAP);
        fetch(32'h107, 5);    idle(GAP);
        fetch(32'h180, HANG); idle(GAP);
        fetch(32'h200, 1);    idle(GAP);
        fetch(32'h300, TIMEOUT - 1); idle(GAP);
        fetch(32'h310, TIMEOUT);     idle(GAP);

        // Reset two cycles into REQ, then a stray ack after the reset edge.
        sl_hang  = 1'b1;
        ibus_adr = 32'h400;
        ibus_cyc = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_wb_cyc_before", 32'(wb_cyc), 32'd1);
        rst      = 1'b1;
        ibus_cyc = 1'b0;
        @(negedge clk);
        check_eq("midrst_wb_cyc", 32'(wb_cyc), 32'd0);
        check_eq("midrst_ibus_ack", 32'(ibus_ack), 32'd0);
        check_eq("midrst_ibus_rdt", ibus_rdt, 32'h0);
        check_eq("midrst_wb_adr", wb_adr, 32'h0);
        check_eq("midrst_err", 32'(err), 32'd0);
        rst      = 1'b0;
        sl_force = 1'b1;
        @(negedge clk);
        sl_force = 1'b0;
        check_eq("stray_ack_ignored", 32'(ibus_ack), 32'd0);
        check_eq("stray_ack_wb_cyc", 32'(wb_cyc), 32'd0);
        @(negedge clk);
        check_eq("stray_ack_ignored2", 32'(ibus_ack), 32'd0);
        check_eq("stray_ack_rdt", ibus_rdt, 32'h0);
        sl_hang = 1'b0;
`ifdef SERV_IBUS_PREFETCH_EN
        m_pf_vld = 1'b0;
`endif
        idle(GAP);

        // Randomized fetches, some sequential, some hung or at the boundary.
        last_a = 32'h200;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) ra = last_a + 32'd4;
            else                           ra = $urandom;
            if ($urandom_range(0, 9) == 0) rw = HANG;
            else                           rw = $urandom_range(0, TIMEOUT + 1);
            fetch(ra, rw);
            last_a = {ra[31:2], 2'b00};
            idle(GAP);
        end

`ifdef SERV_IBUS_PREFETCH_EN
        // Buffer hit, then a branch away while the next prefetch is in flight.
        fetch(32'h0, 0); idle(GAP);
        fetch(32'h4, 3);
        n0 = sl_n_cyc;
        check_eq("pf8_inflight", 32'(wb_cyc), 32'd1);
        check_eq("pf8_adr", wb_adr, 32'h8);
        ibus_adr = 32'h40;
        ibus_cyc = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (ibus_ack) seen = 1'b1;
        end
        check_eq("branch_ack_seen", 32'(seen), 32'd1);
        check_eq("branch_rdt", ibus_rdt, mem_word(32'h40));
        check_eq("branch_err", 32'(err), 32'd0);
        check_eq("branch_wb_cycles", 32'(sl_n_cyc - n0), 32'd2);
        check_eq("branch_discarded_adr", sl_adr_log[$-1], 32'h8);
        check_eq("branch_wb_adr", sl_last_adr, 32'h40);
        ibus_cyc = 1'b0;
        m_pf_tag = 32'h44;
        m_pf_vld = 1'b1;
        idle(GAP);
        fetch(32'h44, 2); idle(GAP);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
